apple_placer: RTL and testbench
===============================

# apple_placer

Chooses a pseudo-random empty cell of the playfield for the next apple. It sits directly downstream of field_calculate. On a request, it takes a snapshot of the packed field vector and the empty-cell count, draws a target rank from a free-running LFSR, and scans the snapshot one cell per clock until it finds the target-th empty cell. It returns that cell's index and coordinates with a one-cycle done pulse; field_calculate writes the apple into the field.

## Interface
- SIZE_X, 10, grid width in cells
- SIZE_Y, 10, grid height in cells
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
- N (localparam), SIZE_X*SIZE_Y, cell count; IW = $clog2(N), XW = $clog2(SIZE_X), YW = $clog2(SIZE_Y)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  start request; sampled only in IDLE
- field  in  2*N  packed field; cell i = y*SIZE_X+x occupies bits [2i+1:2i]; 2'b00 = empty, any other value = occupied
- empty_cells  in  16  number of empty cells claimed by the field owner
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse, result valid
- found  out  1  1 = apple placed, 0 = no empty cell found
- apple_idx  out  IW  linear index of the chosen cell
- apple_x  out  XW  column of the chosen cell
- apple_y  out  YW  row of the chosen cell

## Operation
- LFSR: 16-bit Galois, taps mask 16'hB400. It steps every clock in every state and resets to LFSR_SEED.
- FSM states: IDLE, SCAN, DONE.
- IDLE, req=1:
  - Latch field into snap.
  - target = (lfsr * empty_cells) >> 16, computed as a 32-bit product and truncated to 16 bits. The lfsr value used is the register value in the req cycle.
  - Clear idx, x, y and the empty-cell counter cnt.
  - If empty_cells == 0: go to DONE with found=0. Otherwise go to SCAN.
- SCAN, one cell per clock, cell idx examined from snap:
  - If the cell is empty and cnt == target: register apple_idx/x/y, found=1, go to DONE.
  - Else if the cell is empty: cnt++.
  - If idx == N-1 with no match: found=0, go to DONE; apple_idx/x/y are left unchanged.
  - Otherwise advance: idx++, x++. When x == SIZE_X-1, x wraps to 0 and y++. No divider is used.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- req outside IDLE is ignored; there is no queueing. The field input may change freely after the req cycle.
- Outputs: apple_idx/x/y/found hold their values until the next done. busy = (state != IDLE).
- Reset values: state IDLE, busy=0, done=0, found=0, apple_idx=0, apple_x=0, apple_y=0, lfsr=LFSR_SEED.
- Reset mid-scan aborts immediately to IDLE with the reset values. No done pulse is produced.

## Timing
- Cycle numbering: cycle 0 is the cycle in which req is sampled high in IDLE.
- Match at cell m: SCAN covers cycles 1..m+1; done=1 in cycle m+2.
- empty_cells == 0: done=1, found=0 in cycle 1.
- No match: done=1, found=0 in cycle N+1. Worst-case latency is N+1.
- Result outputs update on the same edge that raises done.
- Back-to-back requests: the earliest next accept is the cycle after done (IDLE). A req held high continuously therefore restarts in the cycle after each done.
- The first cycle with rst low has lfsr == LFSR_SEED.

## Test plan
- Reset: hold rst 3 cycles with req=1 -> busy=0, done=0, found=0, apple_idx/x/y=0 throughout and in the first cycle after release.
- All-empty field, empty_cells=100, req in the first cycle after reset release (lfsr=16'hACE1) -> target 67; done in cycle 69 with found=1, apple_idx=67, apple_x=7, apple_y=6.
- Single empty cell at index 57, empty_cells=1, any LFSR state -> target 0; done in cycle 59, found=1, apple_x=7, apple_y=5.
- empty_cells=0 with an arbitrary field -> done in cycle 1, found=0, previous apple_idx/x/y unchanged, busy high only in cycle 1.
- All cells occupied (2'b01) with empty_cells=3 -> done in cycle 101, found=0; a second req pulse at cycle 40 is ignored, with exactly one done pulse.
- Start a scan as in the second scenario, assert rst in cycle 20 -> next cycle IDLE, busy=0, no done pulse; a fresh req afterwards with lfsr reseeded reproduces apple_idx=67.

Source files
------------

// File: rtl/apple_placer.sv
// apple_placer: picks a pseudo-random empty playfield cell for the next apple.
// Snapshots the field on request and scans it one cell per clock.
module apple_placer #(
    parameter int          SIZE_X    = 10,
    parameter int          SIZE_Y    = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         N         = SIZE_X * SIZE_Y,
    localparam int         IW        = $clog2(N),
    localparam int         XW        = $clog2(SIZE_X),
    localparam int         YW        = $clog2(SIZE_Y)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [2*N-1:0] field,
    input  logic [15:0]    empty_cells,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [IW-1:0]  apple_idx,
    output logic [XW-1:0]  apple_x,
    output logic [YW-1:0]  apple_y
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [XW-1:0] LAST_X   = XW'(SIZE_X - 1);

    logic [1:0]     state;
    logic [15:0]    lfsr;
    logic [15:0]    lfsr_next;
    logic [2*N-1:0] snap;
    logic [15:0]    target;
    logic [15:0]    target_next;
    logic [15:0]    cnt;
    logic [IW-1:0]  idx;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           cell_empty;

    // Galois step: shift right, fold taps in when the outgoing bit is 1
    assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400)
                               : {1'b0, lfsr[15:1]};

    // Scale the LFSR value into the range [0, empty_cells)
    assign target_next = 16'(({16'b0, lfsr} * {16'b0, empty_cells}) >> 16);

    // The snapshot shifts down as the scan advances, so the current cell is always in bits [1:0]
    assign cell_empty = (snap[1:0] == 2'b00);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lfsr      <= LFSR_SEED;
            snap      <= '0;
            target    <= '0;
            cnt       <= '0;
            idx       <= '0;
            x         <= '0;
            y         <= '0;
            found     <= 1'b0;
            apple_idx <= '0;
            apple_x   <= '0;
            apple_y   <= '0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        snap   <= field;
                        target <= target_next;
                        cnt    <= '0;
                        idx    <= '0;
                        x      <= '0;
                        y      <= '0;
                        if (empty_cells == 16'd0) begin
                            found <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (cell_empty && cnt == target) begin
                        apple_idx <= idx;
                        apple_x   <= x;
                        apple_y   <= y;
                        found     <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        if (cell_empty) begin
                            cnt <= cnt + 16'd1;
                        end
                        if (idx == LAST_IDX) begin
                            found <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            idx  <= idx + IW'(1);
                            snap <= snap >> 2;
                            if (x == LAST_X) begin
                                x <= '0;
                                y <= y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placer.sv
// tb_apple_placer: directed bench for apple_placer.
// Each step drives one request and checks latency, pulse count and result.
module tb_apple_placer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [199:0] field;
    logic [15:0]  empty_cells;
    logic         busy;
    logic         done;
    logic         found;
    logic [6:0]   apple_idx;
    logic [3:0]   apple_x;
    logic [3:0]   apple_y;

    int   checks   = 0;
    int   failures = 0;
    int   done_cyc;
    int   ndone;
    logic busy_log [0:127];

    apple_placer dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .field      (field),
        .empty_cells(empty_cells),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .apple_idx  (apple_idx),
        .apple_x    (apple_x),
        .apple_y    (apple_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycle c runs from 1ns after one rising edge to the next; c=0 is the req cycle.
    task automatic run(input int pulse_at, input int rst_at, input int limit);
        done_cyc = -1;
        ndone    = 0;
        for (int c = 0; c <= limit; c++) begin
            req = (c == 0) || (c == pulse_at);
            rst = (c == rst_at);
            if (c < 128) busy_log[c] = busy;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req         = 1'b1;
        field       = '0;
        empty_cells = 16'd100;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_found", 32'(found), 32'd0);
            chk("rst_idx", 32'(apple_idx), 32'd0);
            chk("rst_xy", 32'({apple_x, apple_y}), 32'd0);
        end
        rst = 1'b0;
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_idx", 32'(apple_idx), 32'd0);

        // Seeded scan aborted by reset in cycle 20
        run(-1, 20, 20);
        chk("abort_busy1", 32'(busy_log[1]), 32'd1);
        chk("abort_ndone", 32'(ndone), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_found", 32'(found), 32'd0);
        chk("abort_idx", 32'(apple_idx), 32'd0);

        // Fresh req with reseeded LFSR: target 67
        run(-1, -1, 80);
        chk("seed_cyc", 32'(done_cyc), 32'd69);
        chk("seed_ndone", 32'(ndone), 32'd1);
        chk("seed_found", 32'(found), 32'd1);
        chk("seed_idx", 32'(apple_idx), 32'd67);
        chk("seed_x", 32'(apple_x), 32'd7);
        chk("seed_y", 32'(apple_y), 32'd6);

        // Single empty cell at 57
        field              = {100{2'b01}};
        field[114 +: 2]    = 2'b00;
        empty_cells        = 16'd1;
        run(-1, -1, 70);
        chk("one_cyc", 32'(done_cyc), 32'd59);
        chk("one_ndone", 32'(ndone), 32'd1);
        chk("one_found", 32'(found), 32'd1);
        chk("one_idx", 32'(apple_idx), 32'd57);
        chk("one_x", 32'(apple_x), 32'd7);
        chk("one_y", 32'(apple_y), 32'd5);

        // No empty cells claimed
        field       = {100{2'b10}};
        field[7:0]  = 8'h00;
        empty_cells = 16'd0;
        run(-1, -1, 5);
        chk("zero_cyc", 32'(done_cyc), 32'd1);
        chk("zero_ndone", 32'(ndone), 32'd1);
        chk("zero_found", 32'(found), 32'd0);
        chk("zero_idx", 32'(apple_idx), 32'd57);
        chk("zero_xy", 32'({apple_x, apple_y}), 32'h75);
        chk("zero_busy1", 32'(busy_log[1]), 32'd1);
        chk("zero_busy2", 32'(busy_log[2]), 32'd0);

        // Full field with a stale count; mid-scan req must be ignored
        field       = {100{2'b01}};
        empty_cells = 16'd3;
        run(40, -1, 110);
        chk("full_cyc", 32'(done_cyc), 32'd101);
        chk("full_ndone", 32'(ndone), 32'd1);
        chk("full_found", 32'(found), 32'd0);
        chk("full_idx", 32'(apple_idx), 32'd57);
        chk("full_xy", 32'({apple_x, apple_y}), 32'h75);
        chk("full_busy40", 32'(busy_log[40]), 32'd1);
        chk("full_busy102", 32'(busy_log[102]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
